// File: rtl/csi2_rx_csr.sv
// ---------------------------------------------------------------------------
// csi2_rx_csr
//
// AXI4-Lite register block for the CSI-2 receiver. It holds the D-PHY enable
// and the SCCB slave address that the power-up sequencer programs. It also
// returns the ID, the live status bits and the error counter to software.
//
// Optional feature: define CSI2_RX_CSR_FRAME_CNT_EN to build the 32-bit
// frame counter at 0x14. Without it 0x14 is unmapped and frame_stb is ignored.
//
// Register map (decode on addr[7:2]):
//   0x00 ID        RO   ID_VALUE
//   0x04 CTRL      RW   [0] dphy_en
//   0x08 SCCB_ADDR RW   [6:0] slave address
//   0x0C STATUS    RO   [0] dphy_locked (live), [1] err_seen (sticky)
//   0x10 ERR_CNT   RO   [15:0] saturating; any write clears it and err_seen
//   0x14 FRAME_CNT RO   wrapping frame count (optional)
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   csr_aw*/w*/b*/ar*/r*     AXI4-Lite slave, 32-bit data, 8-bit address
//   dphy_locked              D-PHY lock level (already in clk domain)
//   err_stb, frame_stb       single-cycle event pulses
//   dphy_en                  CTRL[0]
//   sccb_slave_addr          SCCB_ADDR[6:0]
// ---------------------------------------------------------------------------
module csi2_rx_csr #(
    parameter logic [31:0] ID_VALUE      = 32'h4353_4932,
    parameter logic [6:0]  SCCB_ADDR_RST = 7'h1a
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  csr_awaddr,
    input  logic        csr_awvalid,
    output logic        csr_awready,
    input  logic [31:0] csr_wdata,
    input  logic [3:0]  csr_wstrb,
    input  logic        csr_wvalid,
    output logic        csr_wready,
    output logic [1:0]  csr_bresp,
    output logic        csr_bvalid,
    input  logic        csr_bready,
    input  logic [7:0]  csr_araddr,
    input  logic        csr_arvalid,
    output logic        csr_arready,
    output logic [31:0] csr_rdata,
    output logic [1:0]  csr_rresp,
    output logic        csr_rvalid,
    input  logic        csr_rready,
    input  logic        dphy_locked,
    input  logic        err_stb,
    input  logic        frame_stb,
    output logic        dphy_en,
    output logic [6:0]  sccb_slave_addr
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic        aw_held_reg;
    logic [7:0]  aw_addr_reg;
    logic        w_held_reg;
    logic [31:0] w_data_reg;
    logic [3:0]  w_strb_reg;
    logic        bvalid_reg;
    logic [1:0]  bresp_reg;
    logic        rvalid_reg;
    logic [31:0] rdata_reg;
    logic [1:0]  rresp_reg;
    logic        dphy_en_reg;
    logic [6:0]  sccb_addr_reg;
    logic [15:0] err_cnt_reg;
    logic        err_seen_reg;

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        commit;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [5:0]  wr_idx;
    logic        wr_mapped;
    logic [31:0] rdata_next;
    logic [1:0]  rresp_next;

`ifdef CSI2_RX_CSR_FRAME_CNT_EN
    logic [31:0] frame_cnt_reg;
`endif

    assign csr_awready     = ~aw_held_reg & ~bvalid_reg;
    assign csr_wready      = ~w_held_reg & ~bvalid_reg;
    assign csr_arready     = ~rvalid_reg;
    assign csr_bvalid      = bvalid_reg;
    assign csr_bresp       = bresp_reg;
    assign csr_rvalid      = rvalid_reg;
    assign csr_rdata       = rdata_reg;
    assign csr_rresp       = rresp_reg;
    assign dphy_en         = dphy_en_reg;
    assign sccb_slave_addr = sccb_addr_reg;

    assign aw_hs = csr_awvalid & csr_awready;
    assign w_hs  = csr_wvalid & csr_wready;
    assign ar_hs = csr_arvalid & csr_arready;

    // The half arriving this cycle bypasses its buffer so a write whose
    // second half lands now commits on this same edge.
    assign wr_addr = aw_held_reg ? aw_addr_reg : csr_awaddr;
    assign wr_data = w_held_reg  ? w_data_reg  : csr_wdata;
    assign wr_strb = w_held_reg  ? w_strb_reg  : csr_wstrb;
    assign wr_idx  = wr_addr[7:2];
    assign commit  = (aw_held_reg | aw_hs) & (w_held_reg | w_hs) & ~bvalid_reg;

    always_comb begin
        wr_mapped = 1'b0;
        case (wr_idx)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4: wr_mapped = 1'b1;
`ifdef CSI2_RX_CSR_FRAME_CNT_EN
            6'd5:                         wr_mapped = 1'b1;
`endif
            default:                      wr_mapped = 1'b0;
        endcase
    end

    // Write channel: one-deep AW and W buffers, freed together on B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_reg <= 1'b0;
            aw_addr_reg <= '0;
            w_held_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else if (bvalid_reg && csr_bready) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                aw_addr_reg <= csr_awaddr;
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                w_data_reg <= csr_wdata;
                w_strb_reg <= csr_wstrb;
            end
            if (commit) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // RW fields: only byte lane 0 carries live bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dphy_en_reg   <= 1'b0;
            sccb_addr_reg <= SCCB_ADDR_RST;
        end else if (commit && wr_strb[0]) begin
            if (wr_idx == 6'd1) dphy_en_reg   <= wr_data[0];
            if (wr_idx == 6'd2) sccb_addr_reg <= wr_data[6:0];
        end
    end

    // Error counter and sticky flag. A clear coinciding with an error pulse
    // keeps that pulse, so the counter restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg  <= '0;
            err_seen_reg <= 1'b0;
        end else if (commit && wr_idx == 6'd4) begin
            err_cnt_reg  <= {15'd0, err_stb};
            err_seen_reg <= err_stb;
        end else if (err_stb) begin
            if (err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
            err_seen_reg <= 1'b1;
        end
    end

`ifdef CSI2_RX_CSR_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
        end else if (frame_stb) begin
            frame_cnt_reg <= frame_cnt_reg + 32'd1;
        end
    end
`endif

    always_comb begin
        rdata_next = '0;
        rresp_next = RESP_OKAY;
        case (csr_araddr[7:2])
            6'd0: rdata_next = ID_VALUE;
            6'd1: rdata_next = {31'd0, dphy_en_reg};
            6'd2: rdata_next = {25'd0, sccb_addr_reg};
            6'd3: rdata_next = {30'd0, err_seen_reg, dphy_locked};
            6'd4: rdata_next = {16'd0, err_cnt_reg};
`ifdef CSI2_RX_CSR_FRAME_CNT_EN
            6'd5: rdata_next = frame_cnt_reg;
`endif
            default: rresp_next = RESP_SLVERR;
        endcase
    end

    // Read channel: data captured at the AR handshake, held until rready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rdata_next;
            rresp_reg  <= rresp_next;
        end else if (rvalid_reg && csr_rready) begin
            rvalid_reg <= 1'b0;
        end
    end

    logic unused_ok;
`ifdef CSI2_RX_CSR_FRAME_CNT_EN
    assign unused_ok = ^{wr_data[31:7], wr_strb[3:1], wr_addr[1:0], csr_araddr[1:0]};
`else
    assign unused_ok = ^{wr_data[31:7], wr_strb[3:1], wr_addr[1:0], csr_araddr[1:0], frame_stb};
`endif

endmodule
